// File: rtl/bp_mc_mmio_pkg.sv
// Shared types for the BlackParrot/manycore MMIO link: EPA layout, device map,
// responder states, a minimal BedRock memory message and the EPA decode helper.
package bp_mc_mmio_pkg;

    localparam int unsigned bp_paddr_width_lp = 40;
    localparam int unsigned bp_data_width_lp  = 64;

    localparam logic [39:0] cfg_dev_base_addr_gp         = 40'h00_0020_0000;
    localparam logic [39:0] clint_dev_base_addr_gp       = 40'h00_0030_0000;
    localparam logic [39:0] bp_cfg_mem_base_cce_ucode_gp = 40'h00_0000_8000;

    typedef struct packed {
        logic [3:0]  dev;
        logic [11:0] addr;
    } bp_epa_s;

    typedef enum logic [3:0] {
        DevCfg   = 4'd0,
        DevUcode = 4'd1,
        DevClint = 4'd2
    } bp_mc_dev_e;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWait,
        StAck,
        StRet
    } bp_mc_state_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [1:0] lce_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_msg_size_e         size;
        bp_bedrock_mem_payload_s      payload;
        logic [bp_paddr_width_lp-1:0] addr;
        bp_bedrock_mem_type_e         msg_type;
    } bp_bedrock_mem_header_s;

    typedef struct packed {
        logic [bp_data_width_lp-1:0] data;
        bp_bedrock_mem_header_s      header;
    } bp_bedrock_mem_msg_s;

    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_bedrock_mem_msg_s);

    typedef struct packed {
        logic       is_byte_op;
        logic       is_hex_op;
        logic       is_unsigned_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    function automatic logic epa_is_mapped(bp_epa_s epa);
        return epa.dev < 4'd3;
    endfunction

    // Offsets are in 64-bit words on the BP side.
    function automatic logic [39:0] epa_to_bp_addr(bp_epa_s epa);
        logic [39:0] off;
        off = {25'b0, epa.addr, 3'b000};
        case (epa.dev)
            DevCfg:   return cfg_dev_base_addr_gp + off;
            DevUcode: return cfg_dev_base_addr_gp + bp_cfg_mem_base_cce_ucode_gp + off;
            DevClint: return clint_dev_base_addr_gp + off;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/bp_mc_mmio_responder_if.sv
// Endpoint in-request/out-response group and BP I/O command/response ports,
// named from the responder's point of view (slave = responder, master = environment).
interface bp_mc_mmio_responder_if #(
    parameter int unsigned mc_data_width_p = 32,
    parameter int unsigned mc_addr_width_p = 28
);
    import bp_mc_mmio_pkg::*;

    logic                         in_v_i;
    logic [mc_data_width_p-1:0]   in_data_i;
    logic [mc_data_width_p/8-1:0] in_mask_i;
    logic [mc_addr_width_p-1:0]   in_addr_i;
    logic                         in_we_i;
    bsg_manycore_load_info_s      in_load_info_i;
    logic                         in_yumi_o;
    logic [mc_data_width_p-1:0]   returning_data_o;
    logic                         returning_v_o;

    bp_bedrock_mem_msg_s          io_cmd_o;
    logic                         io_cmd_v_o;
    logic                         io_cmd_yumi_i;
    bp_bedrock_mem_msg_s          io_resp_i;
    logic                         io_resp_v_i;
    logic                         io_resp_ready_o;

    modport slave (
        input  in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i, in_load_info_i,
        output in_yumi_o, returning_data_o, returning_v_o,
        output io_cmd_o, io_cmd_v_o,
        input  io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        output io_resp_ready_o
    );

    modport master (
        output in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i, in_load_info_i,
        input  in_yumi_o, returning_data_o, returning_v_o,
        input  io_cmd_o, io_cmd_v_o,
        output io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        input  io_resp_ready_o
    );

endinterface

// File: rtl/bp_mc_load_extract.sv
// Selects a byte/half/word from a 32-bit load result and sign- or zero-extends it
// according to the manycore load info.
module bp_mc_load_extract
    import bp_mc_mmio_pkg::*;
(
    input  logic [31:0]             data_i,
    input  bsg_manycore_load_info_s load_info_i,
    output logic [31:0]             data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = data_i[{load_info_i.part_sel, 3'b000} +: 8];
        half_sel = load_info_i.part_sel[1] ? data_i[31:16] : data_i[15:0];
        sext     = !load_info_i.is_unsigned_op;
        if (load_info_i.is_byte_op) begin
            data_o = {{24{sext & byte_sel[7]}}, byte_sel};
        end else if (load_info_i.is_hex_op) begin
            data_o = {{16{sext & half_sel[15]}}, half_sel};
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/bp_mc_mmio_responder.sv
// Turns manycore endpoint remote requests into single uncached BedRock commands on the
// BP I/O port and returns the completion; one transaction in flight at a time.
module bp_mc_mmio_responder
    import bp_mc_mmio_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_mc_mmio_responder_if.slave bus_io,
    output logic [7:0]            err_count_o,
    output logic [7:0]            stray_count_o
);

    bp_mc_state_e            state_q;
    bp_bedrock_mem_msg_s     cmd_d, cmd_q;
    logic                    cmd_v_q, resp_ready_q, in_yumi_q, ret_v_q, ret_zero_q;
    logic [31:0]             resp_data_q, ret_data_q, load_data;
    bsg_manycore_load_info_s load_info_q;
    logic [7:0]              err_q, stray_q;
    bp_epa_s                 epa;
    logic                    mapped;

    assign epa    = bus_io.in_addr_i[15:0];
    assign mapped = epa_is_mapped(epa);

    always_comb begin
        cmd_d                       = '0;
        cmd_d.header.msg_type       = bus_io.in_we_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        cmd_d.header.size           = e_bedrock_msg_size_8;
        cmd_d.header.payload.lce_id = 2'b10;
        cmd_d.header.addr           = epa_to_bp_addr(epa);
        cmd_d.data                  = 64'(bus_io.in_data_i);
    end

    bp_mc_load_extract u_load_extract (
        .data_i      (resp_data_q),
        .load_info_i (load_info_q),
        .data_o      (load_data)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            cmd_v_q      <= 1'b0;
            resp_ready_q <= 1'b1;
            in_yumi_q    <= 1'b0;
            ret_v_q      <= 1'b0;
            ret_zero_q   <= 1'b0;
            ret_data_q   <= '0;
            resp_data_q  <= '0;
            load_info_q  <= '0;
            err_q        <= '0;
            stray_q      <= '0;
        end else begin
            in_yumi_q <= 1'b0;
            ret_v_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Nothing is outstanding, so any response here is discarded.
                    if (bus_io.io_resp_v_i && stray_q != 8'hFF) stray_q <= stray_q + 8'd1;
                    if (bus_io.in_v_i) begin
                        load_info_q  <= bus_io.in_load_info_i;
                        ret_zero_q   <= bus_io.in_we_i || !mapped;
                        resp_ready_q <= 1'b0;
                        if (mapped) begin
                            cmd_q   <= cmd_d;
                            cmd_v_q <= 1'b1;
                            state_q <= StCmd;
                        end else begin
                            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                            in_yumi_q <= 1'b1;
                            state_q   <= StAck;
                        end
                    end
                end
                StCmd: begin
                    if (bus_io.io_cmd_yumi_i) begin
                        cmd_v_q      <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (bus_io.io_resp_v_i) begin
                        resp_data_q  <= bus_io.io_resp_i.data[31:0];
                        resp_ready_q <= 1'b0;
                        in_yumi_q    <= 1'b1;
                        state_q      <= StAck;
                    end
                end
                StAck: begin
                    ret_v_q    <= 1'b1;
                    ret_data_q <= ret_zero_q ? 32'd0 : load_data;
                    state_q    <= StRet;
                end
                StRet: begin
                    resp_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.io_cmd_o         = cmd_q;
    assign bus_io.io_cmd_v_o       = cmd_v_q;
    assign bus_io.io_resp_ready_o  = resp_ready_q;
    assign bus_io.in_yumi_o        = in_yumi_q;
    assign bus_io.returning_v_o    = ret_v_q;
    assign bus_io.returning_data_o = ret_data_q;
    assign err_count_o             = err_q;
    assign stray_count_o           = stray_q;

    // Upper EPA bits, the store mask and the upper response half carry no meaning here.
    logic unused_sigs;
    assign unused_sigs = ^{bus_io.in_addr_i[$bits(bus_io.in_addr_i)-1:16], bus_io.in_mask_i,
                           bus_io.io_resp_i.header, bus_io.io_resp_i.data[63:32]};

endmodule

// File: tb/tb_bp_mc_mmio_responder.sv
// Directed table-driven bench for bp_mc_mmio_responder with a scripted BP I/O side
// plus hand sequences for stall, saturation and mid-transaction reset.
module tb_bp_mc_mmio_responder;
    import bp_mc_mmio_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic [7:0] err_count, stray_count;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;
    int exp_stray = 0;

    always #5 clk = ~clk;

    bp_mc_mmio_responder_if bus ();

    bp_mc_mmio_responder dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .bus_io        (bus),
        .err_count_o   (err_count),
        .stray_count_o (stray_count)
    );

    typedef struct {
        logic                    we;
        logic [3:0]              dev;
        logic [11:0]             off;
        logic [31:0]             wdata;
        bsg_manycore_load_info_s li;
        logic [31:0]             rdata;
        logic [39:0]             exp_addr;
        logic [31:0]             exp_ret;
    } vec_t;

    localparam int NumVec = 14;
    vec_t vecs[NumVec];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int stall);
        logic mapped;
        bp_bedrock_mem_msg_s exp_cmd;
        mapped                        = (v.dev < 4'd3);
        exp_cmd                       = '0;
        exp_cmd.header.msg_type       = v.we ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        exp_cmd.header.size           = e_bedrock_msg_size_8;
        exp_cmd.header.payload.lce_id = 2'b10;
        exp_cmd.header.addr           = v.exp_addr;
        exp_cmd.data                  = {32'h0, v.wdata};

        bus.in_v_i         = 1'b1;
        bus.in_we_i        = v.we;
        bus.in_data_i      = v.wdata;
        bus.in_mask_i      = 4'hF;
        bus.in_addr_i      = {12'h5A5, v.dev, v.off};
        bus.in_load_info_i = v.li;
        @(negedge clk);
        if (mapped) begin
            check("cmd_v", 128'(bus.io_cmd_v_o), 128'd1);
            check("cmd_addr", 128'(bus.io_cmd_o.header.addr), 128'(v.exp_addr));
            check("cmd_type", 128'(bus.io_cmd_o.header.msg_type), 128'(exp_cmd.header.msg_type));
            check("cmd_size", 128'(bus.io_cmd_o.header.size), 128'(e_bedrock_msg_size_8));
            check("cmd_lce", 128'(bus.io_cmd_o.header.payload.lce_id), 128'd2);
            check("cmd_data", 128'(bus.io_cmd_o.data), 128'(exp_cmd.data));
            check("cmd_ready", 128'(bus.io_resp_ready_o), 128'd0);
            check("cmd_yumi", 128'(bus.in_yumi_o), 128'd0);
            for (int i = 0; i < stall; i++) begin
                bus.io_resp_v_i    = 1'($urandom_range(0, 1));
                bus.io_resp_i.data = {$urandom, $urandom};
                @(negedge clk);
                check("stall_cmd_v", 128'(bus.io_cmd_v_o), 128'd1);
                check("stall_cmd", 128'(bus.io_cmd_o), 128'(exp_cmd));
                check("stall_ready", 128'(bus.io_resp_ready_o), 128'd0);
                check("stall_yumi", 128'(bus.in_yumi_o), 128'd0);
            end
            bus.io_resp_v_i   = 1'b0;
            bus.io_cmd_yumi_i = 1'b1;
            @(negedge clk);
            bus.io_cmd_yumi_i = 1'b0;
            check("wait_cmd_v", 128'(bus.io_cmd_v_o), 128'd0);
            check("wait_ready", 128'(bus.io_resp_ready_o), 128'd1);
            check("wait_yumi", 128'(bus.in_yumi_o), 128'd0);
            bus.io_resp_v_i    = 1'b1;
            bus.io_resp_i      = '0;
            bus.io_resp_i.data = {32'hCAFE_F00D, v.rdata};
            @(negedge clk);
            bus.io_resp_v_i = 1'b0;
        end else begin
            check("unmapped_no_cmd", 128'(bus.io_cmd_v_o), 128'd0);
        end
        check("ack_yumi", 128'(bus.in_yumi_o), 128'd1);
        check("ack_ret_v", 128'(bus.returning_v_o), 128'd0);
        check("ack_ready", 128'(bus.io_resp_ready_o), 128'd0);
        @(negedge clk);
        bus.in_v_i = 1'b0;
        if (!mapped && exp_err != 255) exp_err++;
        check("ret_v", 128'(bus.returning_v_o), 128'd1);
        check("ret_data", 128'(bus.returning_data_o), 128'(v.exp_ret));
        check("ret_yumi", 128'(bus.in_yumi_o), 128'd0);
        check("err_count", 128'(err_count), 128'(exp_err));
        check("stray_count", 128'(stray_count), 128'(exp_stray));
        @(negedge clk);
        check("idle_ret_v", 128'(bus.returning_v_o), 128'd0);
        check("idle_ready", 128'(bus.io_resp_ready_o), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          we    dev    off      wdata         li (byte,hex,uns,ps)  rdata          addr            ret
        vecs[0]  = '{1'b0, 4'd2,  12'h004, 32'hA5A5A5A5, 5'b0_0_0_00, 32'hDEADBEEF, 40'h30_0020, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 4'd0,  12'h010, 32'h12345678, 5'b0_0_0_00, 32'hFFFFFFFF, 40'h20_0080, 32'h0};
        vecs[2]  = '{1'b0, 4'd0,  12'h001, 32'h0,        5'b1_0_0_11, 32'h80123456, 40'h20_0008, 32'hFFFFFF80};
        vecs[3]  = '{1'b0, 4'd1,  12'h002, 32'h0,        5'b1_0_1_11, 32'h80123456, 40'h20_8010, 32'h00000080};
        vecs[4]  = '{1'b0, 4'd2,  12'hFFF, 32'h0,        5'b0_1_0_10, 32'hC0001234, 40'h30_7FF8, 32'hFFFFC000};
        vecs[5]  = '{1'b0, 4'd0,  12'h000, 32'h0,        5'b1_0_0_01, 32'h00007F00, 40'h20_0000, 32'h0000007F};
        vecs[6]  = '{1'b0, 4'd1,  12'h000, 32'h0,        5'b0_1_0_00, 32'h12348001, 40'h20_8000, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 4'd2,  12'h100, 32'h0,        5'b0_1_1_10, 32'h8001C000, 40'h30_0800, 32'h00008001};
        vecs[8]  = '{1'b0, 4'd5,  12'h123, 32'h0,        5'b0_0_0_00, 32'h0,        40'h0,       32'h0};
        vecs[9]  = '{1'b1, 4'd15, 12'h000, 32'hDEADBEEF, 5'b0_0_0_00, 32'h0,        40'h0,       32'h0};
        vecs[10] = '{1'b0, 4'd0,  12'h7FF, 32'h0,        5'b0_0_1_00, 32'h87654321, 40'h20_3FF8, 32'h87654321};
        vecs[11] = '{1'b0, 4'd3,  12'h000, 32'h0,        5'b0_0_0_00, 32'h0,        40'h0,       32'h0};
        vecs[12] = '{1'b0, 4'd2,  12'h008, 32'h0,        5'b1_0_0_00, 32'h123456FE, 40'h30_0040, 32'hFFFFFFFE};
        vecs[13] = '{1'b0, 4'd0,  12'h020, 32'h0,        5'b1_0_1_10, 32'h00AB0000, 40'h20_0100, 32'h000000AB};

        reset_n            = 1'b0;
        bus.in_v_i         = 1'b0;
        bus.in_we_i        = 1'b0;
        bus.in_data_i      = '0;
        bus.in_mask_i      = '0;
        bus.in_addr_i      = '0;
        bus.in_load_info_i = '0;
        bus.io_cmd_yumi_i  = 1'b0;
        bus.io_resp_i      = '0;
        bus.io_resp_v_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_v", 128'(bus.io_cmd_v_o), 128'd0);
        check("rst_yumi", 128'(bus.in_yumi_o), 128'd0);
        check("rst_ret_v", 128'(bus.returning_v_o), 128'd0);
        check("rst_ret_data", 128'(bus.returning_data_o), 128'd0);
        check("rst_ready", 128'(bus.io_resp_ready_o), 128'd1);
        check("rst_err", 128'(err_count), 128'd0);
        check("rst_stray", 128'(stray_count), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NumVec; i++) do_txn(vecs[i], 0);

        // Command held off for 10 cycles with random response noise.
        do_txn(vecs[0], 10);

        v = vecs[8];
        for (int i = 0; i < 300; i++) do_txn(v, 0);
        check("err_saturated", 128'(err_count), 128'd255);

        // Reset while waiting on the BP response; the late response is stray.
        bus.in_v_i         = 1'b1;
        bus.in_we_i        = 1'b0;
        bus.in_addr_i      = {12'h000, 4'd2, 12'h004};
        bus.in_load_info_i = '0;
        @(negedge clk);
        bus.io_cmd_yumi_i = 1'b1;
        @(negedge clk);
        bus.io_cmd_yumi_i = 1'b0;
        check("rw_ready", 128'(bus.io_resp_ready_o), 128'd1);
        reset_n = 1'b0;
        #1;
        exp_err = 0;
        check("rw_cmd_v", 128'(bus.io_cmd_v_o), 128'd0);
        check("rw_yumi", 128'(bus.in_yumi_o), 128'd0);
        check("rw_err", 128'(err_count), 128'd0);
        bus.in_v_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.io_resp_v_i    = 1'b1;
        bus.io_resp_i.data = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        bus.io_resp_v_i = 1'b0;
        exp_stray = 1;
        check("rw_stray", 128'(stray_count), 128'd1);
        check("rw_no_yumi", 128'(bus.in_yumi_o), 128'd0);
        check("rw_no_ret", 128'(bus.returning_v_o), 128'd0);
        @(negedge clk);
        check("rw_no_yumi2", 128'(bus.in_yumi_o), 128'd0);
        check("rw_idle_ready", 128'(bus.io_resp_ready_o), 128'd1);
        do_txn(vecs[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
